// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - state type, default coin/price tables and packed-table lookup for vend_ctrl_gen
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_DISPENSE,
    ST_CHANGE
  } vend_state_t;

  localparam int MAX_TBL_W = 256;
  localparam int MAX_VAL_W = 32;

  localparam logic [19:0] DEF_COIN_VALS = {5'd20, 5'd10, 5'd5, 5'd1};
  localparam logic [19:0] DEF_PRICES    = {5'd25, 5'd20, 5'd15, 5'd10};

  // Entry idx of a table packed as consecutive w-bit fields, entry 0 in the LSBs.
  function automatic logic [MAX_VAL_W-1:0] pick(input logic [MAX_TBL_W-1:0] vec,
                                                input int idx, input int w);
    logic [MAX_TBL_W-1:0] sh;
    sh = vec >> (idx * w);
    return sh[MAX_VAL_W-1:0] & ~({MAX_VAL_W{1'b1}} << w);
  endfunction

endpackage

// File: rtl/vend_hold_timer.sv
// rtl/vend_hold_timer.sv - loadable down-counter timing the DISPENSE and CHANGE hold windows
module vend_hold_timer #(
  parameter int HOLD_CYC = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  logic [CNT_W-1:0] cnt;

  // Loading HOLD_CYC-1 makes done rise after the state has been held HOLD_CYC cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(HOLD_CYC - 1);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/vend_ctrl_gen.sv
// rtl/vend_ctrl_gen.sv - parametrised vending controller top; VEND_STOCK_EN enables per-product stock
module vend_ctrl_gen
  import vend_pkg::*;
#(
  parameter int                        N_DRINKS   = 4,
  parameter int                        N_COINS    = 4,
  parameter int                        VAL_W      = 5,
  parameter logic [N_COINS*VAL_W-1:0]  COIN_VALS  = DEF_COIN_VALS,
  parameter logic [N_DRINKS*VAL_W-1:0] PRICES     = DEF_PRICES,
  parameter int                        STOCK_W    = 4,
  parameter int                        STOCK_INIT = 5,
  parameter int                        HOLD_CYC   = 8,
  localparam int                       DW         = (N_DRINKS > 1) ? $clog2(N_DRINKS) : 1,
  localparam int                       CW         = (N_COINS > 1) ? $clog2(N_COINS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                op_start,
  input  logic                coin_in,
  input  logic [CW-1:0]       coin_type,
  input  logic [DW-1:0]       drink_type,
  input  logic                go,
  input  logic                cancel_flag,
  input  logic                restock,
  output logic                open,
  output logic [VAL_W-1:0]    credit,
  output logic                hold_ind,
  output logic [N_DRINKS-1:0] drinktk_ind,
  output logic                can_take,
  output logic                charge_ind,
  output logic [VAL_W-1:0]    charge_val,
  output logic                no_money,
  output logic                no_num,
  output logic                over_flow,
  output logic                coin_rej
);

  vend_state_t         state, state_d;
  logic [VAL_W-1:0]    credit_d, charge_d, coin_val, price;
  logic [VAL_W:0]      sum;
  logic [N_DRINKS-1:0] drink_d;
  logic                no_money_d, no_num_d, over_flow_d, coin_acc;
  logic                tmr_load, tmr_en, tmr_done;
  logic                stock_dec, stock_empty, drink_ok, coin_ok;

  assign drink_ok = int'(drink_type) < N_DRINKS;
  assign coin_ok  = int'(coin_type) < N_COINS;
  assign coin_val = VAL_W'(pick(MAX_TBL_W'(COIN_VALS), int'(coin_type), VAL_W));
  assign price    = VAL_W'(pick(MAX_TBL_W'(PRICES), int'(drink_type), VAL_W));
  assign sum      = {1'b0, credit} + {1'b0, coin_val};
  assign tmr_en   = (state == ST_DISPENSE) || (state == ST_CHANGE);

  vend_hold_timer #(.HOLD_CYC(HOLD_CYC)) u_hold (
    .clk   (clk),
    .reset (reset),
    .load  (tmr_load),
    .en    (tmr_en),
    .done  (tmr_done)
  );

`ifdef VEND_STOCK_EN
  logic [STOCK_W-1:0] stock [N_DRINKS];

  assign stock_empty = drink_ok && (stock[drink_type] == '0);

  // Restock outranks a same-cycle sale so the shelf always ends up full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_DRINKS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
    end else if (restock) begin
      for (int i = 0; i < N_DRINKS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
    end else if (stock_dec) begin
      stock[drink_type] <= stock[drink_type] - STOCK_W'(1);
    end
  end
`else
  localparam int unused_stock_cfg = STOCK_W + STOCK_INIT;
  logic unused_stock_sig;

  assign stock_empty      = 1'b0;
  assign unused_stock_sig = restock ^ stock_dec;
`endif

  always_comb begin
    state_d     = state;
    credit_d    = credit;
    charge_d    = charge_val;
    drink_d     = drinktk_ind;
    no_money_d  = 1'b0;
    no_num_d    = 1'b0;
    over_flow_d = 1'b0;
    coin_acc    = 1'b0;
    tmr_load    = 1'b0;
    stock_dec   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (op_start) begin
          state_d  = ST_ACCEPT;
          credit_d = '0;
        end
      end

      // cancel_flag > go > coin_in; a coin losing arbitration is rejected below.
      ST_ACCEPT: begin
        if (cancel_flag) begin
          charge_d = credit;
          credit_d = '0;
          if (credit != '0) begin
            state_d  = ST_CHANGE;
            tmr_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (go) begin
          if (drink_ok) begin
            if (stock_empty) begin
              no_num_d = 1'b1;
            end else if (credit < price) begin
              no_money_d = 1'b1;
            end else begin
              stock_dec = 1'b1;
              charge_d  = credit - price;
              credit_d  = '0;
              drink_d   = N_DRINKS'(1) << drink_type;
              state_d   = ST_DISPENSE;
              tmr_load  = 1'b1;
            end
          end
        end else if (coin_in && coin_ok) begin
          if (sum[VAL_W]) begin
            over_flow_d = 1'b1;
          end else begin
            credit_d = sum[VAL_W-1:0];
            coin_acc = 1'b1;
          end
        end
      end

      ST_DISPENSE: begin
        if (tmr_done) begin
          drink_d = '0;
          if (charge_val != '0) begin
            state_d  = ST_CHANGE;
            tmr_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_CHANGE: begin
        if (tmr_done) begin
          state_d  = ST_IDLE;
          charge_d = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Level indications follow the next state so every output comes straight from a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      open        <= 1'b0;
      credit      <= '0;
      hold_ind    <= 1'b0;
      drinktk_ind <= '0;
      can_take    <= 1'b0;
      charge_ind  <= 1'b0;
      charge_val  <= '0;
      no_money    <= 1'b0;
      no_num      <= 1'b0;
      over_flow   <= 1'b0;
      coin_rej    <= 1'b0;
    end else begin
      state       <= state_d;
      open        <= (state_d != ST_IDLE);
      credit      <= credit_d;
      hold_ind    <= (state_d == ST_DISPENSE);
      drinktk_ind <= drink_d;
      can_take    <= (state_d == ST_DISPENSE);
      charge_ind  <= (state_d == ST_CHANGE);
      charge_val  <= charge_d;
      no_money    <= no_money_d;
      no_num      <= no_num_d;
      over_flow   <= over_flow_d;
      coin_rej    <= coin_in && !coin_acc;
    end
  end

endmodule

// File: tb/tb_vend_ctrl_gen.sv
// tb/tb_vend_ctrl_gen.sv - scoreboard bench for vend_ctrl_gen: expected output snapshots queued by stimulus, checked by a change monitor
module tb_vend_ctrl_gen;

  typedef struct packed {
    logic       open;
    logic [4:0] credit;
    logic       hold;
    logic [3:0] drk;
    logic       take;
    logic       chg;
    logic [4:0] cval;
    logic       nm;
    logic       nn;
    logic       of;
    logic       rej;
  } snap_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       op_start = 1'b0, coin_in = 1'b0, go = 1'b0, cancel_flag = 1'b0, restock = 1'b0;
  logic [1:0] coin_type = '0, drink_type = '0;
  logic       open, hold_ind, can_take, charge_ind, no_money, no_num, over_flow, coin_rej;
  logic [4:0] credit, charge_val;
  logic [3:0] drinktk_ind;

  int    n_cmp = 0;
  int    n_fail = 0;
  snap_t exp_q[$];
  int    gap_q[$];
  snap_t m;
  snap_t prev;
  bit    prev_valid = 0;
  int    cyc_since = 0;

  vend_ctrl_gen dut (
    .clk(clk), .reset(reset), .op_start(op_start), .coin_in(coin_in), .coin_type(coin_type),
    .drink_type(drink_type), .go(go), .cancel_flag(cancel_flag), .restock(restock),
    .open(open), .credit(credit), .hold_ind(hold_ind), .drinktk_ind(drinktk_ind),
    .can_take(can_take), .charge_ind(charge_ind), .charge_val(charge_val),
    .no_money(no_money), .no_num(no_num), .over_flow(over_flow), .coin_rej(coin_rej)
  );

  always #5 clk = ~clk;

  function automatic snap_t sample();
    return {open, credit, hold_ind, drinktk_ind, can_take, charge_ind, charge_val,
            no_money, no_num, over_flow, coin_rej};
  endfunction

  // Monitor: every change of the output vector must match the next queued snapshot.
  always @(negedge clk) begin
    snap_t cur, e;
    int g;
    cur = sample();
    cyc_since++;
    if (!prev_valid || cur != prev) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change got=%h t=%0t", cur, $time);
      end else begin
        e = exp_q.pop_front();
        g = gap_q.pop_front();
        if (cur !== e) begin
          n_fail++;
          $display("FAIL snapshot got=%h want=%h t=%0t", cur, e, $time);
        end
        if (g != 0) begin
          n_cmp++;
          if (cyc_since != g) begin
            n_fail++;
            $display("FAIL hold_gap got=%0d want=%0d t=%0t", cyc_since, g, $time);
          end
        end
      end
      prev = cur;
      prev_valid = 1;
      cyc_since = 0;
    end
  end

  task automatic ex(input int gap);
    exp_q.push_back(m);
    gap_q.push_back(gap);
  endtask

  task automatic drive(input logic op, input logic cn, input int ct, input logic gg,
                       input int dt, input logic cx, input logic rs);
    op_start = op; coin_in = cn; coin_type = 2'(ct); go = gg; drink_type = 2'(dt);
    cancel_flag = cx; restock = rs;
    @(negedge clk);
    op_start = 0; coin_in = 0; go = 0; cancel_flag = 0; restock = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic t_op();         drive(1, 0, 0, 0, 0, 0, 0); endtask
  task automatic t_coin(int ct); drive(0, 1, ct, 0, 0, 0, 0); endtask
  task automatic t_go(int dt);   drive(0, 0, 0, 1, dt, 0, 0); endtask
  task automatic t_cancel();     drive(0, 0, 0, 0, 0, 1, 0); endtask
  task automatic t_restock();    drive(0, 0, 0, 0, 0, 0, 1); endtask

  // Exact-money purchase of drink 2 (price 20) with a single 20 coin.
  task automatic buy2();
    m.open = 1; ex(0); t_op();
    m.credit = 20; ex(0); t_coin(3);
    m.credit = 0; m.hold = 1; m.drk = 4'b0100; m.take = 1; ex(0); t_go(2);
    m.open = 0; m.hold = 0; m.drk = 0; m.take = 0; ex(8); idle(9);
  endtask

  initial begin
    snap_t now;
    m = '0;
    ex(0);
    reset = 1;
    idle(3);
    reset = 0;
    idle(1);

    // Coin, go and cancel in IDLE: only the coin reacts.
    m.rej = 1; ex(0); t_coin(1);
    m.rej = 0; ex(1); idle(1);
    t_go(0); t_cancel(); idle(1);

    // 10+10, buy drink 1 (15); coin during DISPENSE rejected; change 5.
    m.open = 1; ex(0); t_op();
    m.credit = 10; ex(0); t_coin(2);
    m.credit = 20; ex(0); t_coin(2);
    m.credit = 0; m.hold = 1; m.drk = 4'b0010; m.take = 1; m.cval = 5; ex(0); t_go(1);
    idle(2);
    m.rej = 1; ex(3); t_coin(0);
    m.rej = 0; ex(1);
    m.hold = 0; m.drk = 0; m.take = 0; m.chg = 1; ex(4);
    m.chg = 0; m.cval = 0; m.open = 0; ex(8);
    idle(14);

    // Credit 5 against price 10: no_money, session stays open, cancel refunds 10.
    m.open = 1; ex(0); t_op();
    m.credit = 5; ex(0); t_coin(1);
    m.nm = 1; ex(0); t_go(0);
    m.nm = 0; ex(1); idle(1);
    m.credit = 10; ex(0); t_coin(1);
    m.credit = 0; m.chg = 1; m.cval = 10; ex(0); t_cancel();
    m.chg = 0; m.cval = 0; m.open = 0; ex(8); idle(9);

    // Overflow at 31+1; then go drink 3 (25) with a colliding coin, change 6.
    m.open = 1; ex(0); t_op();
    m.credit = 20; ex(0); t_coin(3);
    m.credit = 30; ex(0); t_coin(2);
    m.credit = 31; ex(0); t_coin(0);
    m.of = 1; m.rej = 1; ex(0); t_coin(0);
    m.of = 0; m.rej = 0; ex(1); idle(1);
    m.credit = 0; m.hold = 1; m.drk = 4'b1000; m.take = 1; m.cval = 6; m.rej = 1; ex(0);
    drive(0, 1, 0, 1, 3, 0, 0);
    m.rej = 0; ex(1);
    m.hold = 0; m.drk = 0; m.take = 0; m.chg = 1; ex(7);
    m.chg = 0; m.cval = 0; m.open = 0; ex(8); idle(17);

    // Cancel with zero credit goes straight back to IDLE.
    m.open = 1; ex(0); t_op();
    m.open = 0; ex(0); t_cancel(); idle(1);

    // Cancel and coin together with credit 15.
    m.open = 1; ex(0); t_op();
    m.credit = 10; ex(0); t_coin(2);
    m.credit = 15; ex(0); t_coin(1);
    m.credit = 0; m.chg = 1; m.cval = 15; m.rej = 1; ex(0); drive(0, 1, 3, 0, 0, 1, 0);
    m.rej = 0; ex(1);
    m.chg = 0; m.cval = 0; m.open = 0; ex(7); idle(9);

    // Asynchronous reset in the middle of dispensing drink 2.
    m.open = 1; ex(0); t_op();
    m.credit = 20; ex(0); t_coin(3);
    m.credit = 0; m.hold = 1; m.drk = 4'b0100; m.take = 1; ex(0); t_go(2);
    idle(3);
    #2;
    m = '0; ex(0);
    reset = 1;
    #1;
    now = sample();
    n_cmp++;
    if (now !== '0) begin
      n_fail++;
      $display("FAIL async_reset got=%h want=0", now);
    end
    @(negedge clk);
    reset = 0;
    idle(2);

    // Five purchases of drink 2 empty its shelf (stock back at 5 after the reset).
    for (int i = 0; i < 5; i++) buy2();
`ifdef VEND_STOCK_EN
    m.open = 1; ex(0); t_op();
    m.credit = 20; ex(0); t_coin(3);
    m.nn = 1; ex(0); t_go(2);
    m.nn = 0; ex(1); idle(1);
    t_restock(); idle(1);
    m.credit = 0; m.hold = 1; m.drk = 4'b0100; m.take = 1; ex(0); t_go(2);
    m.open = 0; m.hold = 0; m.drk = 0; m.take = 0; ex(8); idle(9);
`else
    buy2();
    t_restock(); idle(1);
    buy2();
`endif

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
